ioctl_upload_reader: RTL and testbench

- Reverse path of the ROM-pack download: streams a byte range out of the PMD85 SDRAM into data_io's upload (save) interface, so the OSD can write RAM or ROM-pack images back to SD.
- Requests the SDRAM port from the core and issues single-byte reads.
- Prefetches the bytes into a small FIFO and hands them to data_io one byte per ioctl_rd strobe.

---
 rtl/ioctl_upload_pkg.sv | 16 +
 rtl/ioctl_upload_reader_fifo.sv | 78 +++++++
 rtl/ioctl_upload_reader.sv | 238 +++++++++++++++++++++++
 tb/tb_ioctl_upload_reader.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ioctl_upload_pkg.sv
// ioctl_upload_pkg
// Shared definitions for the SDRAM-to-data_io upload reader: the controller
// state encoding and the default SDRAM byte-address width.
package ioctl_upload_pkg;

  localparam int ADDR_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_GNT = 3'd1,
    ISSUE    = 3'd2,
    WAIT_RDY = 3'd3,
    DRAIN    = 3'd4
  } upl_state_e;

endpackage

// File: rtl/ioctl_upload_reader_fifo.sv
// upload_fifo
// Synchronous byte FIFO between the SDRAM read side and data_io.
// Ports:
//   clk_sys, reset_n : clock, asynchronous active-low reset
//   push, din        : write a byte (ignored when full or flushing)
//   pop              : drop the head byte (ignored when empty or flushing)
//   flush            : empty the FIFO; wins over push and pop
//   dout             : head byte, combinational
//   empty, full      : occupancy flags
//   count            : current number of stored bytes
// DEPTH must be a power of two, at least 2. Pointers carry one extra wrap
// bit so full and empty can be told apart when the indices are equal.
module upload_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  input  logic                     flush,
  output logic [7:0]               dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]     mem_q [DEPTH];
  logic [7:0]     mem_d [DEPTH];
  logic           do_push;
  logic           do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;
  assign dout  = mem_q[rd_ptr_q[PTR_W-1:0]];

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q[PTR_W-1:0]] = din;
        wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/ioctl_upload_reader.sv
// ioctl_upload_reader
// Streams a byte range out of SDRAM into data_io's upload interface so the
// OSD can save RAM / ROM-pack images. Takes the SDRAM port from the core,
// issues single-byte reads one at a time and prefetches them into a small
// FIFO that data_io drains one byte per ioctl_rd.
// Ports:
//   clk_sys, reset_n          : clock, asynchronous active-low reset
//   start, abort              : one-cycle control pulses
//   base_addr, length         : transfer range, sampled on start
//   ioctl_upload              : transfer active
//   ioctl_din/_valid, ioctl_rd: byte handoff to data_io
//   bus_req, bus_gnt          : SDRAM port arbitration with the core
//   sdram_addr/_rd/_dout/_ready: single-byte read port
//   done                      : end-of-transfer / abort pulse
//   underrun                  : sticky, ioctl_rd seen with nothing to give
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | no transfer; waiting for start
// WAIT_GNT | holding bus_req; waiting for grant and a free FIFO slot
// ISSUE    | one-cycle sdram_rd at rd_addr
// WAIT_RDY | one read in flight; waiting for its data (also abort wait)
// DRAIN    | all reads done, bus released; waiting for data_io to empty
module ioctl_upload_reader
  import ioctl_upload_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              ioctl_upload,
  output logic [7:0]        ioctl_din,
  output logic              ioctl_din_valid,
  input  logic              ioctl_rd,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic              sdram_rd,
  input  logic [7:0]        sdram_dout,
  input  logic              sdram_ready,
  output logic              done,
  output logic              underrun
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] ALMOST_FULL = CNT_W'(FIFO_DEPTH - 1);

  upl_state_e        state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W:0]   rd_left_q, rd_left_d;
  logic [ADDR_W:0]   out_left_q, out_left_d;
  logic              upload_q, upload_d;
  logic              bus_req_q, bus_req_d;
  logic              done_q, done_d;
  logic              underrun_q, underrun_d;
  logic              abort_pend_q, abort_pend_d;
  // Read return is registered before it reaches the FIFO, which keeps the
  // SDRAM data path off the FIFO write port and the full/next-state logic.
  logic              rd_vld_q, rd_vld_d;
  logic [7:0]        rd_data_q, rd_data_d;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_flush;
  logic              fifo_empty;
  logic              fifo_full;
  logic [7:0]        fifo_dout;
  logic [CNT_W-1:0]  fifo_count;

  upload_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .push    (fifo_push),
    .din     (rd_data_q),
    .pop     (fifo_pop),
    .flush   (fifo_flush),
    .dout    (fifo_dout),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  assign fifo_pop        = ioctl_rd && !fifo_empty;
  assign ioctl_din       = fifo_dout;
  assign ioctl_din_valid = !fifo_empty;
  assign ioctl_upload    = upload_q;
  assign bus_req         = bus_req_q;
  assign sdram_addr      = rd_addr_q;
  assign sdram_rd        = (state_q == ISSUE);
  assign done            = done_q;
  assign underrun        = underrun_q;

  always_comb begin
    state_d      = state_q;
    rd_addr_d    = rd_addr_q;
    rd_left_d    = rd_left_q;
    out_left_d   = out_left_q;
    upload_d     = upload_q;
    bus_req_d    = bus_req_q;
    done_d       = 1'b0;
    underrun_d   = underrun_q;
    abort_pend_d = abort_pend_q;
    rd_vld_d     = sdram_ready;
    rd_data_d    = sdram_dout;
    fifo_push    = 1'b0;
    fifo_flush   = 1'b0;

    if (fifo_pop) begin
      out_left_d = out_left_q - (ADDR_W+1)'(1);
    end
    if (ioctl_rd && fifo_empty) begin
      underrun_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        // start takes priority over a coincident abort, which is simply
        // not looked at here.
        if (start) begin
          underrun_d = 1'b0;
          if (length != '0) begin
            rd_addr_d    = base_addr;
            rd_left_d    = length;
            out_left_d   = length;
            upload_d     = 1'b1;
            bus_req_d    = 1'b1;
            abort_pend_d = 1'b0;
            state_d      = WAIT_GNT;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      WAIT_GNT: begin
        if (abort) begin
          fifo_flush = 1'b1;
          bus_req_d  = 1'b0;
          upload_d   = 1'b0;
          done_d     = 1'b1;
          state_d    = IDLE;
        end else if (bus_gnt && !fifo_full) begin
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        rd_addr_d = rd_addr_q + ADDR_W'(1);
        rd_left_d = rd_left_q - (ADDR_W+1)'(1);
        state_d   = WAIT_RDY;
        // The strobe is already out, so an abort here must still let the
        // read return before the port is considered free.
        if (abort) begin
          abort_pend_d = 1'b1;
          bus_req_d    = 1'b0;
          fifo_flush   = 1'b1;
        end
      end

      WAIT_RDY: begin
        if (abort || abort_pend_q) begin
          abort_pend_d = 1'b1;
          bus_req_d    = 1'b0;
          fifo_flush   = 1'b1;
          if (rd_vld_q) begin
            abort_pend_d = 1'b0;
            upload_d     = 1'b0;
            done_d       = 1'b1;
            state_d      = IDLE;
          end
        end else if (rd_vld_q) begin
          fifo_push = 1'b1;
          if (rd_left_q == '0) begin
            bus_req_d = 1'b0;
            state_d   = DRAIN;
          end else if (((fifo_count == ALMOST_FULL) && !fifo_pop) || !bus_gnt) begin
            state_d = WAIT_GNT;
          end else begin
            state_d = ISSUE;
          end
        end
      end

      DRAIN: begin
        if (abort) begin
          fifo_flush = 1'b1;
          upload_d   = 1'b0;
          done_d     = 1'b1;
          state_d    = IDLE;
        end else if (out_left_q == '0) begin
          upload_d = 1'b0;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      rd_addr_q    <= '0;
      rd_left_q    <= '0;
      out_left_q   <= '0;
      upload_q     <= 1'b0;
      bus_req_q    <= 1'b0;
      done_q       <= 1'b0;
      underrun_q   <= 1'b0;
      abort_pend_q <= 1'b0;
      rd_vld_q     <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      rd_addr_q    <= rd_addr_d;
      rd_left_q    <= rd_left_d;
      out_left_q   <= out_left_d;
      upload_q     <= upload_d;
      bus_req_q    <= bus_req_d;
      done_q       <= done_d;
      underrun_q   <= underrun_d;
      abort_pend_q <= abort_pend_d;
      rd_vld_q     <= rd_vld_d;
      rd_data_q    <= rd_data_d;
    end
  end

endmodule

// File: tb/tb_ioctl_upload_reader.sv
// Directed bench for ioctl_upload_reader: SDRAM model with 3-cycle read
// latency returning addr[7:0], scoreboard of expected bytes filled at start
// and drained by the data_io consumer model.
module tb_ioctl_upload_reader;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] base_addr = '0;
  logic [16:0] length = '0;
  logic        ioctl_upload;
  logic [7:0]  ioctl_din;
  logic        ioctl_din_valid;
  logic        ioctl_rd;
  logic        bus_req;
  logic        bus_gnt = 1'b0;
  logic [15:0] sdram_addr;
  logic        sdram_rd;
  logic [7:0]  sdram_dout = '0;
  logic        sdram_ready = 1'b0;
  logic        done;
  logic        underrun;

  logic        cons_rd = 1'b0;
  logic        man_rd = 1'b0;
  logic        cons_en = 1'b0;
  assign ioctl_rd = cons_rd | man_rd;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int n_rd = 0, n_rdy = 0, n_done = 0, n_deliv = 0, n_req = 0, n_upl = 0;
  int fall_rdy = 0;
  int first_lat = -1;
  int last_rdy_cyc = 0;
  int lat_cnt = 0;
  logic [15:0] mem_addr = '0;
  logic        prev_req = 1'b0;
  logic        prev_valid = 1'b0;
  logic [15:0] obs_addr[$];
  logic [7:0]  exp_q[$];

  ioctl_upload_reader dut (
    .clk_sys         (clk_sys),
    .reset_n         (reset_n),
    .start           (start),
    .abort           (abort),
    .base_addr       (base_addr),
    .length          (length),
    .ioctl_upload    (ioctl_upload),
    .ioctl_din       (ioctl_din),
    .ioctl_din_valid (ioctl_din_valid),
    .ioctl_rd        (ioctl_rd),
    .bus_req         (bus_req),
    .bus_gnt         (bus_gnt),
    .sdram_addr      (sdram_addr),
    .sdram_rd        (sdram_rd),
    .sdram_dout      (sdram_dout),
    .sdram_ready     (sdram_ready),
    .done            (done),
    .underrun        (underrun)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s did not match", tag);
    end
  endtask

  // Monitor, consumer and SDRAM model share one negedge process so the
  // order sample -> consume -> drive is fixed.
  always @(negedge clk_sys) begin
    cyc++;
    if (sdram_rd) begin
      n_rd++;
      obs_addr.push_back(sdram_addr);
    end
    if (done) n_done++;
    if (bus_req) n_req++;
    if (ioctl_upload) n_upl++;
    if (prev_req && !bus_req) fall_rdy = n_rdy;
    prev_req = bus_req;
    if (ioctl_din_valid && !prev_valid && first_lat < 0) first_lat = cyc - last_rdy_cyc;
    prev_valid = ioctl_din_valid;

    if (cons_rd) begin
      cons_rd = 1'b0;
    end else if (cons_en && ioctl_din_valid) begin
      if (exp_q.size() == 0) check("sb_extra_byte", exp_q.size(), 1);
      else check("sb_byte", ioctl_din, exp_q.pop_front());
      n_deliv++;
      cons_rd = 1'b1;
    end

    if (!reset_n) begin
      lat_cnt = 0;
      sdram_ready = 1'b0;
    end else begin
      sdram_ready = 1'b0;
      if (lat_cnt != 0) begin
        lat_cnt--;
        if (lat_cnt == 0) begin
          sdram_ready = 1'b1;
          sdram_dout = mem_addr[7:0];
          n_rdy++;
          last_rdy_cyc = cyc;
        end
      end
      if (sdram_rd) begin
        lat_cnt = 3;
        mem_addr = sdram_addr;
      end
    end
  end

  task automatic pulse_start(input logic [15:0] b, input logic [16:0] l, input logic with_abort);
    @(negedge clk_sys);
    base_addr = b;
    length = l;
    start = 1'b1;
    abort = with_abort;
    for (int i = 0; i < int'(l); i++) exp_q.push_back(8'(b + 16'(i)));
    @(negedge clk_sys);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    int b;
    bit seen;
    b = n_done;
    seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk_sys);
      if (n_done != b) seen = 1'b1;
    end
    check(tag, 32'(seen), 1);
  endtask

  task automatic check_addrs(input string tag, input int from, input logic [15:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      if (from + i < obs_addr.size()) check(tag, obs_addr[from + i], 32'(16'(b + 16'(i))));
      else check({tag, "_missing"}, obs_addr.size(), from + i + 1);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({ioctl_upload, ioctl_din, ioctl_din_valid, bus_req, sdram_addr,
                sdram_rd, done, underrun});
  endfunction

  initial begin
    int rb, rdb, db, dlv, ab, qb, ub;
    bit hit;

    // reset
    repeat (3) @(negedge clk_sys);
    check("reset_outputs", all_outs(), 0);
    bus_gnt = 1'b1;
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    // basic 4-byte transfer
    rb = n_rdy; rdb = n_rd; db = n_done; dlv = n_deliv; ab = obs_addr.size();
    cons_en = 1'b1;
    pulse_start(16'h1000, 17'd4, 1'b0);
    wait_done("t1_done_seen", 300);
    repeat (4) @(negedge clk_sys);
    check("t1_done_count", n_done - db, 1);
    check("t1_delivered", n_deliv - dlv, 4);
    check("t1_reads", n_rd - rdb, 4);
    check("t1_underrun", 32'(underrun), 0);
    check("t1_first_latency", first_lat, 2);
    check("t1_req_fall_after_ready", fall_rdy - rb, 4);
    check("t1_upload_low", 32'(ioctl_upload), 0);
    check_addrs("t1_addr", ab, 16'h1000, 4);
    check("t1_sb_left", exp_q.size(), 0);

    // address wrap
    rdb = n_rd; ab = obs_addr.size(); dlv = n_deliv;
    pulse_start(16'hFFFE, 17'd4, 1'b0);
    wait_done("t2_done_seen", 300);
    repeat (3) @(negedge clk_sys);
    check_addrs("t2_addr_wrap", ab, 16'hFFFE, 4);
    check("t2_delivered", n_deliv - dlv, 4);

    // zero length
    qb = n_req; rdb = n_rd; ub = n_upl; db = n_done;
    pulse_start(16'h0123, 17'd0, 1'b0);
    check("t3_done_next_cycle", 32'(done), 1);
    repeat (6) @(negedge clk_sys);
    check("t3_done_count", n_done - db, 1);
    check("t3_no_bus_req", n_req - qb, 0);
    check("t3_no_sdram_rd", n_rd - rdb, 0);
    check("t3_no_upload", n_upl - ub, 0);

    // FIFO-full stall then release
    cons_en = 1'b0;
    rdb = n_rd; dlv = n_deliv; ab = obs_addr.size();
    pulse_start(16'h2000, 17'd10, 1'b0);
    repeat (50) @(negedge clk_sys);
    check("t4_stall_reads", n_rd - rdb, 4);
    check("t4_stall_valid", 32'(ioctl_din_valid), 1);
    check("t4_stall_head", 32'(ioctl_din), 0);
    check("t4_stall_bus_req", 32'(bus_req), 1);
    cons_en = 1'b1;
    wait_done("t4_done_seen", 600);
    repeat (3) @(negedge clk_sys);
    check("t4_reads", n_rd - rdb, 10);
    check("t4_delivered", n_deliv - dlv, 10);
    check_addrs("t4_addr", ab, 16'h2000, 10);

    // abort while the 3rd read is in flight
    rdb = n_rd; rb = n_rdy; db = n_done;
    pulse_start(16'h3000, 17'd8, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk_sys);
      if (n_rd - rdb >= 3) hit = 1'b1;
    end
    check("t5_third_read_seen", 32'(hit), 1);
    @(negedge clk_sys);
    cons_en = 1'b0;
    abort = 1'b1;
    @(negedge clk_sys);
    abort = 1'b0;
    check("t5_bus_req_dropped", 32'(bus_req), 0);
    check("t5_upload_held", 32'(ioctl_upload), 1);
    check("t5_fifo_flushed", 32'(ioctl_din_valid), 0);
    wait_done("t5_done_seen", 50);
    check("t5_ready_before_done", n_rdy - rb, 3);
    check("t5_upload_low", 32'(ioctl_upload), 0);
    repeat (6) @(negedge clk_sys);
    check("t5_data_discarded", 32'(ioctl_din_valid), 0);
    check("t5_no_more_reads", n_rd - rdb, 3);
    check("t5_done_count", n_done - db, 1);
    exp_q.delete();
    dlv = n_deliv; ab = obs_addr.size();
    cons_en = 1'b1;
    pulse_start(16'h4000, 17'd2, 1'b0);
    wait_done("t5b_done_seen", 200);
    repeat (3) @(negedge clk_sys);
    check("t5b_delivered", n_deliv - dlv, 2);
    check_addrs("t5b_addr", ab, 16'h4000, 2);

    // underrun, then start (with coincident abort) clears it
    cons_en = 1'b0;
    dlv = n_deliv;
    pulse_start(16'h5000, 17'd3, 1'b0);
    man_rd = 1'b1;
    @(negedge clk_sys);
    man_rd = 1'b0;
    check("t6_underrun_set", 32'(underrun), 1);
    cons_en = 1'b1;
    wait_done("t6_done_seen", 200);
    repeat (3) @(negedge clk_sys);
    check("t6_delivered_full_count", n_deliv - dlv, 3);
    check("t6_underrun_sticky", 32'(underrun), 1);
    dlv = n_deliv;
    pulse_start(16'h5100, 17'd1, 1'b1);
    check("t6_start_clears_underrun", 32'(underrun), 0);
    check("t6_start_beats_abort", 32'(ioctl_upload), 1);
    wait_done("t6b_done_seen", 200);
    repeat (3) @(negedge clk_sys);
    check("t6b_delivered", n_deliv - dlv, 1);
    check("t6_sb_left", exp_q.size(), 0);

    // asynchronous reset mid-transfer
    cons_en = 1'b0;
    rdb = n_rd;
    pulse_start(16'h6000, 17'd6, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk_sys);
      if (n_rd - rdb >= 2) hit = 1'b1;
    end
    check("t7_reads_started", 32'(hit), 1);
    check("t7_busy_before_reset", 32'(bus_req), 1);
    #2 reset_n = 1'b0;
    #1 check("t7_async_reset_outputs", all_outs(), 0);
    db = n_done;
    repeat (5) @(negedge clk_sys);
    check("t7_no_done_on_reset", n_done - db, 0);
    check("t7_outputs_held_zero", all_outs(), 0);
    exp_q.delete();
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
